// File: rtl/jg3_sweep_ctrl_if.sv
// Signal bundle between the lab top level and the JG3 sweep controller.
// master: lab top / JG3 side. slave: the sweep controller.
interface jg3_sweep_ctrl_if;
  logic       start;
  logic       mode;
  logic [2:0] abc_in;
  logic       x_in;
  logic       y_in;
  logic [2:0] abc_out;
  logic       busy;
  logic       done;
  logic [7:0] x_table;
  logic [7:0] y_table;
  logic [3:0] x_count;
  logic [3:0] y_count;

  modport master (
    output start, mode, abc_in, x_in, y_in,
    input  abc_out, busy, done, x_table, y_table, x_count, y_count
  );

  modport slave (
    input  start, mode, abc_in, x_in, y_in,
    output abc_out, busy, done, x_table, y_table, x_count, y_count
  );
endinterface

// File: rtl/jg3_sweep_ctrl.sv
// JG3 sweep controller: steps the JG3 ABC input through all eight codes (or one
// selected code), holds each for SETTLE cycles, and records X/Y at the end of
// each hold into truth tables and ones-counts.
module jg3_sweep_ctrl #(
  parameter int unsigned SETTLE = 1  // hold cycles per code, 1..15
) (
  input logic               clk,
  input logic               rst_n,
  jg3_sweep_ctrl_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [3:0] CntLast = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] last_q, last_d;
  logic [2:0] abc_q, abc_d;
  logic       done_q, done_d;
  logic [7:0] x_table_q, x_table_d;
  logic [7:0] y_table_q, y_table_d;
  logic [3:0] x_count_q, x_count_d;
  logic [3:0] y_count_q, y_count_d;

  logic accept;
  logic capture;
  logic finish;

  // Decode run events: accepted start, capture edge, and final capture.
  always_comb begin
    accept  = (state_q == StIdle) && bus.start;
    capture = (state_q == StRun) && (cnt_q == CntLast);
    finish  = capture && (abc_q == last_q);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (finish) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: busy is exactly the RUN state, so it can never overlap done.
  always_comb begin
    bus.busy    = (state_q == StRun);
    bus.done    = done_q;
    bus.abc_out = abc_q;
    bus.x_table = x_table_q;
    bus.y_table = y_table_q;
    bus.x_count = x_count_q;
    bus.y_count = y_count_q;
  end

  // Datapath next-state: load on start, count the hold, capture and advance.
  always_comb begin
    cnt_d     = cnt_q;
    last_d    = last_q;
    abc_d     = abc_q;
    done_d    = 1'b0;
    x_table_d = x_table_q;
    y_table_d = y_table_q;
    x_count_d = x_count_q;
    y_count_d = y_count_q;

    if (accept) begin
      abc_d     = bus.mode ? bus.abc_in : 3'd0;
      last_d    = bus.mode ? bus.abc_in : 3'd7;
      cnt_d     = 4'd0;
      x_table_d = 8'd0;
      y_table_d = 8'd0;
      x_count_d = 4'd0;
      y_count_d = 4'd0;
    end else if (state_q == StRun) begin
      if (capture) begin
        x_table_d[abc_q] = bus.x_in;
        y_table_d[abc_q] = bus.y_in;
        x_count_d        = x_count_q + {3'd0, bus.x_in};
        y_count_d        = y_count_q + {3'd0, bus.y_in};
        if (finish) begin
          // Final code stays on abc_out after the run.
          done_d = 1'b1;
        end else begin
          abc_d = abc_q + 3'd1;
          cnt_d = 4'd0;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 4'd0;
      last_q    <= 3'd0;
      abc_q     <= 3'd0;
      done_q    <= 1'b0;
      x_table_q <= 8'd0;
      y_table_q <= 8'd0;
      x_count_q <= 4'd0;
      y_count_q <= 4'd0;
    end else begin
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      abc_q     <= abc_d;
      done_q    <= done_d;
      x_table_q <= x_table_d;
      y_table_q <= y_table_d;
      x_count_q <= x_count_d;
      y_count_q <= y_count_d;
    end
  end

endmodule

// File: tb/tb_jg3_sweep_ctrl.sv
// Bench for jg3_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3), a timeline
// model of each run, a per-cycle compare, and literal checks of lab scenarios.
module tb_jg3_sweep_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jg3_sweep_ctrl_if bus1 ();
  jg3_sweep_ctrl_if bus3 ();

  jg3_sweep_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  jg3_sweep_ctrl #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // JG3 behaviour: X = 1 for codes 5..7, Y = 1 for code 0.
  logic att1 = 1'b1, att3 = 1'b1;
  logic xr1 = 1'b0, yr1 = 1'b0, xr3 = 1'b0, yr3 = 1'b0;
  assign bus1.x_in = att1 ? (bus1.abc_out >= 3'd5) : xr1;
  assign bus1.y_in = att1 ? (bus1.abc_out == 3'd0) : yr1;
  assign bus3.x_in = att3 ? (bus3.abc_out >= 3'd5) : xr3;
  assign bus3.y_in = att3 ? (bus3.abc_out == 3'd0) : yr3;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: each run is a timeline; t counts edges since the start edge.
  bit         m_run  [2] = '{0, 0};
  int         m_t    [2] = '{0, 0};
  logic [2:0] m_first[2] = '{0, 0};
  logic [2:0] m_last [2] = '{0, 0};
  logic [2:0] m_abc  [2] = '{0, 0};
  logic       m_busy [2] = '{0, 0};
  logic       m_done [2] = '{0, 0};
  logic [7:0] m_xt   [2] = '{0, 0};
  logic [7:0] m_yt   [2] = '{0, 0};

  function automatic int settle_of(input int j);
    return (j == 0) ? 1 : 3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2; j++) begin
        m_run[j] = 0; m_t[j] = 0; m_abc[j] = 3'd0; m_busy[j] = 1'b0;
        m_done[j] = 1'b0; m_xt[j] = 8'd0; m_yt[j] = 8'd0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        logic st, md, xi, yi;
        logic [2:0] ai, code;
        int s;
        s  = settle_of(j);
        st = (j == 0) ? bus1.start  : bus3.start;
        md = (j == 0) ? bus1.mode   : bus3.mode;
        ai = (j == 0) ? bus1.abc_in : bus3.abc_in;
        xi = (j == 0) ? bus1.x_in   : bus3.x_in;
        yi = (j == 0) ? bus1.y_in   : bus3.y_in;
        m_done[j] = 1'b0;
        if (m_run[j]) begin
          m_t[j]++;
          if (m_t[j] % s == 0) begin
            code = m_first[j] + 3'(m_t[j] / s - 1);
            m_xt[j][code] = xi;
            m_yt[j][code] = yi;
            if (code == m_last[j]) begin
              m_run[j] = 0; m_busy[j] = 1'b0; m_done[j] = 1'b1;
            end
          end
          if (m_run[j]) m_abc[j] = m_first[j] + 3'(m_t[j] / s);
        end else if (st) begin
          m_first[j] = md ? ai : 3'd0;
          m_last[j]  = md ? ai : 3'd7;
          m_abc[j]   = m_first[j];
          m_t[j]     = 0;
          m_run[j]   = 1;
          m_busy[j]  = 1'b1;
          m_xt[j]    = 8'd0;
          m_yt[j]    = 8'd0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic get_done(input int j);
    return (j == 0) ? bus1.done : bus3.done;
  endfunction

  task automatic set_start(input int j, input logic st);
    if (j == 0) bus1.start = st; else bus3.start = st;
  endtask

  task automatic launch(input int j, input logic md, input logic [2:0] ai);
    if (j == 0) begin bus1.start = 1'b1; bus1.mode = md; bus1.abc_in = ai; end
    else        begin bus3.start = 1'b1; bus3.mode = md; bus3.abc_in = ai; end
  endtask

  // Wait for done; lat = edges from the start edge to the done-rise edge.
  task automatic wait_done(input int j, input bit hold, input int poke, input bit rnd,
                           input bit tog, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1 && !hold) set_start(j, 1'b0);
      if (poke > 0 && n == poke) set_start(j, 1'b1);
      if (poke > 0 && n == poke + 1 && !hold) set_start(j, 1'b0);
      if (rnd) begin
        if (j == 0) begin xr1 = 1'($urandom); yr1 = 1'($urandom); end
        else        begin xr3 = 1'($urandom); yr3 = 1'($urandom); end
        // Scramble the other mode/abc_in mid-run; they must have no effect.
        if (j == 0) begin bus1.mode = 1'($urandom); bus1.abc_in = 3'($urandom); end
        else        begin bus3.mode = 1'($urandom); bus3.abc_in = 3'($urandom); end
      end
      if (tog) xr3 = ~xr3;
      if (get_done(j)) begin
        lat = n - 1;
        break;
      end
    end
    if (lat < 0) chk($sformatf("dut%0d_done_seen", j), 32'(get_done(j)), 32'd1);
  endtask

  task automatic chk_results1(input string tag, input logic [7:0] xt, input logic [7:0] yt,
                              input logic [3:0] xc, input logic [3:0] yc);
    chk({tag, "_x_table"}, 32'(bus1.x_table), 32'(xt));
    chk({tag, "_y_table"}, 32'(bus1.y_table), 32'(yt));
    chk({tag, "_x_count"}, 32'(bus1.x_count), 32'(xc));
    chk({tag, "_y_count"}, 32'(bus1.y_count), 32'(yc));
  endtask

  initial begin
    int lat;
    bus1.start = 1'b0; bus1.mode = 1'b0; bus1.abc_in = 3'd0;
    bus3.start = 1'b0; bus3.mode = 1'b0; bus3.abc_in = 3'd0;

    // Per-cycle compare against the model.
    fork
      forever begin
        @(negedge clk);
        if (chk_en && rst_n) begin
          for (int j = 0; j < 2; j++) begin
            string p;
            p = (j == 0) ? "dut1" : "dut3";
            chk({p, ".abc_out"}, 32'((j == 0) ? bus1.abc_out : bus3.abc_out), 32'(m_abc[j]));
            chk({p, ".busy"}, 32'((j == 0) ? bus1.busy : bus3.busy), 32'(m_busy[j]));
            chk({p, ".done"}, 32'((j == 0) ? bus1.done : bus3.done), 32'(m_done[j]));
            chk({p, ".x_table"}, 32'((j == 0) ? bus1.x_table : bus3.x_table), 32'(m_xt[j]));
            chk({p, ".y_table"}, 32'((j == 0) ? bus1.y_table : bus3.y_table), 32'(m_yt[j]));
            chk({p, ".x_count"}, 32'((j == 0) ? bus1.x_count : bus3.x_count),
                $countones(m_xt[j]));
            chk({p, ".y_count"}, 32'((j == 0) ? bus1.y_count : bus3.y_count),
                $countones(m_yt[j]));
            chk({p, ".busy_and_done"},
                32'((j == 0) ? (bus1.busy & bus1.done) : (bus3.busy & bus3.done)), 32'd0);
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_abc_out", 32'(bus1.abc_out), 32'd0);
    chk("reset_busy", 32'(bus1.busy), 32'd0);
    chk_results1("reset", 8'h00, 8'h00, 4'd0, 4'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Full sweep, SETTLE=1, JG3 attached.
    launch(0, 1'b0, 3'd0);
    wait_done(0, 1'b0, 0, 1'b0, 1'b0, lat);
    chk("sweep_latency", 32'(lat), 32'd8);
    chk_results1("sweep", 8'b1110_0000, 8'b0000_0001, 4'd3, 4'd1);
    @(negedge clk);

    // Single mode, code 110.
    launch(0, 1'b1, 3'b110);
    wait_done(0, 1'b0, 0, 1'b0, 1'b0, lat);
    chk("single_latency", 32'(lat), 32'd1);
    chk_results1("single", 8'b0100_0000, 8'b0000_0000, 4'd1, 4'd0);
    @(negedge clk);

    // SETTLE=3 sweep, X toggling every cycle: captures see 1,0,1,0,... for codes 0..7.
    att3 = 1'b0; xr3 = 1'b0; yr3 = 1'b1;
    launch(1, 1'b0, 3'd0);
    wait_done(1, 1'b0, 0, 1'b0, 1'b1, lat);
    chk("settle3_latency", 32'(lat), 32'd24);
    chk("settle3_x_table", 32'(bus3.x_table), 32'h55);
    chk("settle3_y_table", 32'(bus3.y_table), 32'hff);
    chk("settle3_x_count", 32'(bus3.x_count), 32'd4);
    @(negedge clk);

    // Start pulsed mid-run is ignored.
    launch(0, 1'b0, 3'd0);
    wait_done(0, 1'b0, 3, 1'b0, 1'b0, lat);
    chk("poke_latency", 32'(lat), 32'd8);
    chk_results1("poke", 8'b1110_0000, 8'b0000_0001, 4'd3, 4'd1);
    @(negedge clk);

    // Start held through done: back-to-back run, tables cleared at restart.
    launch(0, 1'b0, 3'd0);
    wait_done(0, 1'b1, 0, 1'b0, 1'b0, lat);
    chk("hold_latency", 32'(lat), 32'd8);
    @(negedge clk);
    set_start(0, 1'b0);
    chk("b2b_busy", 32'(bus1.busy), 32'd1);
    chk("b2b_done_cleared", 32'(bus1.done), 32'd0);
    chk_results1("b2b_cleared", 8'h00, 8'h00, 4'd0, 4'd0);
    wait_done(0, 1'b0, 0, 1'b0, 1'b0, lat);
    chk("b2b_latency", 32'(lat + 1), 32'd8);
    chk_results1("b2b", 8'b1110_0000, 8'b0000_0001, 4'd3, 4'd1);
    @(negedge clk);

    // Reset during cycle 4 of a sweep.
    launch(0, 1'b0, 3'd0);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_abc_out", 32'(bus1.abc_out), 32'd0);
    chk("abort_busy", 32'(bus1.busy), 32'd0);
    chk("abort_done", 32'(bus1.done), 32'd0);
    chk_results1("abort", 8'h00, 8'h00, 4'd0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus1.done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    launch(0, 1'b0, 3'd0);
    wait_done(0, 1'b0, 0, 1'b0, 1'b0, lat);
    chk("resweep_latency", 32'(lat), 32'd8);
    chk_results1("resweep", 8'b1110_0000, 8'b0000_0001, 4'd3, 4'd1);
    @(negedge clk);

    // Randomized runs on both instances.
    for (int it = 0; it < 40; it++) begin
      int j, s, poke;
      logic md;
      logic [2:0] ai;
      j  = int'($urandom_range(0, 1));
      s  = settle_of(j);
      md = 1'($urandom);
      ai = 3'($urandom);
      if (j == 0) att1 = 1'($urandom); else att3 = 1'($urandom);
      poke = (md == 1'b0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 8 * s)) : 0;
      launch(j, md, ai);
      wait_done(j, 1'b0, poke, 1'b1, 1'b0, lat);
      chk($sformatf("rand%0d_latency", it), 32'(lat), 32'(md ? s : 8 * s));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jg3_sweep_ctrl.md
# jg3_sweep_ctrl

Sequencing controller for the JG3 three-input judge. On a start request it drives JG3's `ABC` input, either through all eight codes or through one selected code. It holds each code for a programmable settle time and samples JG3's `X`/`Y` outputs. Results are collected into truth-table registers and ones-counts, with a start/busy/done handshake toward the lab top level.

## Interface
- `SETTLE`, default 1, cycles each code is held on `abc_out` before sampling; legal range 1..15.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  request a run; sampled only in IDLE.
- `mode`  input  1  0 = full sweep 000..111, 1 = single code `abc_in`; sampled with `start`.
- `abc_in`  input  3  code for single mode; sampled with `start`.
- `x_in`  input  1  JG3 `X` output.
- `y_in`  input  1  JG3 `Y` output.
- `abc_out`  output  3  drives JG3 `ABC`.
- `busy`  output  1  run in progress.
- `done`  output  1  one-cycle pulse at run completion.
- `x_table`  output  8  bit k = captured `X` for code k.
- `y_table`  output  8  bit k = captured `Y` for code k.
- `x_count`  output  4  number of captured `X`=1 in last run (0..8).
- `y_count`  output  4  number of captured `Y`=1 in last run (0..8).

## Operation
- States: IDLE, RUN.
- Internal registers:
  - 4-bit settle counter `cnt`.
  - 3-bit `last` code.
- IDLE, when `start`=1 at a rising edge:
  - Load `abc_out` with 000 if `mode`=0, else `abc_in`.
  - Load `last` with 111 if `mode`=0, else `abc_in`.
  - Clear `cnt`, `x_table`, `y_table`, `x_count`, `y_count`.
  - Set `busy`=1 and go to RUN.
- RUN, each edge with `cnt` < SETTLE-1: increment `cnt`; `abc_out` is held.
- RUN, edge with `cnt` == SETTLE-1 (capture edge):
  - Write `x_in`/`y_in` into bit `abc_out` of `x_table`/`y_table`.
  - Add `x_in` to `x_count` and `y_in` to `y_count`; 4-bit, cannot overflow.
  - If `abc_out` == `last`: `busy`<=0, `done`<=1, go to IDLE; `abc_out` holds the final code.
  - Otherwise: `abc_out`<=`abc_out`+1 and `cnt`<=0. No wrap past 111 is possible.
- `done` returns to 0 on the edge after it asserts.
- Tables and counts hold their values in IDLE until the next accepted `start`.
- `start` while `busy`=1 is ignored; no queuing.
- `start` in the `done` cycle (state is IDLE) is accepted and a new run begins; `done` still pulses for exactly one cycle.
- `mode`/`abc_in` changes during RUN have no effect.

## Timing
- Reset (asynchronous, any time, including mid-run): state IDLE, `abc_out`=000, `busy`=0, `done`=0, tables=00000000, counts=0, `cnt`=0. No `done` pulse for an aborted run.
- Call the start edge E0:
  - `busy` is 1 from E0 through the final capture edge.
  - Code i (0-based within the run) is on `abc_out` from edge E0+i·SETTLE to E0+(i+1)·SETTLE.
  - Capture of code i happens at edge E0+(i+1)·SETTLE.
- Sweep latency: `done` rises at E0+8·SETTLE.
- Single-mode latency: `done` rises at E0+SETTLE.
- `busy` and `done` are never 1 in the same cycle.
- JG3 is combinational; SETTLE=1 is sufficient in the standard lab integration.

## Test plan
- Reset, then sweep with SETTLE=1 and JG3 attached:
  - `abc_out` steps 0..7 on consecutive cycles.
  - `done` rises 8 cycles after start.
  - `x_table`=11100000, `y_table`=00000001, `x_count`=3, `y_count`=1.
- Single mode, `abc_in`=110, SETTLE=1: after 1 cycle `done`=1, `x_table`=01000000, `y_table`=00000000, `x_count`=1, `y_count`=0.
- SETTLE=3 sweep with toggling stimulus on `x_in` mid-hold: only the value at each capture edge is recorded; `done` rises at E0+24.
- `start` pulsed during RUN: ignored, results identical to an undisturbed sweep; `start` held high through the `done` cycle produces a back-to-back run with tables cleared at the restart edge.
- `rst_n` asserted at cycle 4 of a sweep: all outputs zero immediately, no `done`; a fresh start after release yields the full sweep results from the first scenario.
